// File: rtl/core_pkg.sv
// Shared types and sizing for the register writeback path.
// Widths and queue depth are fixed here so the entry struct and all users agree.
package core_pkg;

  localparam int AddressBitWidth = 5;
  localparam int DataBitWidth    = 32;
  localparam int LoadQueueDepth  = 4;
  localparam int PtrWidth        = $clog2(LoadQueueDepth);
  localparam int CountWidth      = PtrWidth + 1;

  typedef struct packed {
    logic [AddressBitWidth-1:0] rd;
    logic [DataBitWidth-1:0]    data;
    logic                       filled;
  } load_entry_t;

endpackage

// File: rtl/register_writeback_if.sv
// Bundle of ALU, load-queue, decode-hazard and register-file write signals.
// The slave modport is the writeback block; the master modport drives it.
interface register_writeback_if;
  import core_pkg::*;

  logic                       alu_valid;
  logic [AddressBitWidth-1:0] alu_rd;
  logic [DataBitWidth-1:0]    alu_data;
  logic                       load_issue;
  logic [AddressBitWidth-1:0] load_issue_rd;
  logic                       load_issue_ready;
  logic                       load_resp_valid;
  logic [DataBitWidth-1:0]    load_resp_data;
  logic                       load_resp_error;
  logic [AddressBitWidth-1:0] rs1;
  logic [AddressBitWidth-1:0] rs2;
  logic                       rs1_busy;
  logic                       rs2_busy;
  logic [AddressBitWidth-1:0] rd;
  logic                       rd_write_enable;
  logic [DataBitWidth-1:0]    rd_data_in;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  load_issue, load_issue_rd, load_resp_valid, load_resp_data,
    input  rs1, rs2,
    output load_issue_ready, load_resp_error, rs1_busy, rs2_busy,
    output rd, rd_write_enable, rd_data_in
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output load_issue, load_issue_rd, load_resp_valid, load_resp_data,
    output rs1, rs2,
    input  load_issue_ready, load_resp_error, rs1_busy, rs2_busy,
    input  rd, rd_write_enable, rd_data_in
  );
endinterface

// File: rtl/register_writeback_load_queue.sv
// In-order load queue: entries are allocated at issue, filled by responses in
// issue order, and popped from the head once filled.
module load_queue
  import core_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_i,
  input  logic [AddressBitWidth-1:0] issue_rd_i,
  input  logic                       resp_valid_i,
  input  logic [DataBitWidth-1:0]    resp_data_i,
  input  logic                       pop_i,
  input  logic [AddressBitWidth-1:0] rs1_i,
  input  logic [AddressBitWidth-1:0] rs2_i,
  output logic                       ready_o,
  output logic                       error_o,
  output logic                       head_filled_o,
  output load_entry_t                head_o,
  output logic [LoadQueueDepth-1:0]  rs1_match_o,
  output logic [LoadQueueDepth-1:0]  rs2_match_o
);

  load_entry_t               mem_q [LoadQueueDepth];
  logic [PtrWidth-1:0]       head_q, head_d;
  logic [PtrWidth-1:0]       tail_q, tail_d;
  logic [PtrWidth-1:0]       fill_q, fill_d;
  logic [CountWidth-1:0]     count_q, count_d;
  logic                      error_q, error_d;
  logic [LoadQueueDepth-1:0] valid;
  logic                      issue_accept;
  logic                      fill_accept;

  // An entry is live when its distance from the head is below the count.
  for (genvar gi = 0; gi < LoadQueueDepth; gi++) begin : g_entry
    logic [PtrWidth-1:0] offset;
    assign offset          = PtrWidth'(gi) - head_q;
    assign valid[gi]       = {1'b0, offset} < count_q;
    assign rs1_match_o[gi] = valid[gi] && (mem_q[gi].rd == rs1_i);
    assign rs2_match_o[gi] = valid[gi] && (mem_q[gi].rd == rs2_i);
  end

  assign ready_o       = count_q != CountWidth'(LoadQueueDepth);
  assign error_o       = error_q;
  assign head_o        = mem_q[head_q];
  assign head_filled_o = valid[head_q] && mem_q[head_q].filled;
  assign issue_accept  = issue_i && ready_o;
  assign fill_accept   = resp_valid_i && valid[fill_q] && !mem_q[fill_q].filled;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    error_d = error_q;
    if (pop_i)        head_d = head_q + 1'b1;
    if (issue_accept) tail_d = tail_q + 1'b1;
    if (fill_accept)  fill_d = fill_q + 1'b1;
    if (resp_valid_i && !fill_accept) error_d = 1'b1;
    count_d = count_q + CountWidth'(issue_accept) - CountWidth'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Issue and fill never target the same slot: that needs a full queue, which blocks issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LoadQueueDepth; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < LoadQueueDepth; i++) begin
        if (issue_accept && (tail_q == PtrWidth'(i))) begin
          mem_q[i].rd     <= issue_rd_i;
          mem_q[i].data   <= '0;
          mem_q[i].filled <= 1'b0;
        end else if (fill_accept && (fill_q == PtrWidth'(i))) begin
          mem_q[i].data   <= resp_data_i;
          mem_q[i].filled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Register-file write port arbiter: ALU results take priority over drained loads,
// outputs are registered, and pending destinations are reported as busy to decode.
module register_writeback
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  register_writeback_if.slave  bus
);

  logic                       head_filled;
  load_entry_t                head;
  logic [LoadQueueDepth-1:0]  rs1_match;
  logic [LoadQueueDepth-1:0]  rs2_match;
  logic                       pop;
  logic [AddressBitWidth-1:0] rd_q, rd_d;
  logic [DataBitWidth-1:0]    data_q, data_d;
  logic                       we_q, we_d;

  assign pop = !bus.alu_valid && head_filled;

  load_queue u_load_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_i       (bus.load_issue),
    .issue_rd_i    (bus.load_issue_rd),
    .resp_valid_i  (bus.load_resp_valid),
    .resp_data_i   (bus.load_resp_data),
    .pop_i         (pop),
    .rs1_i         (bus.rs1),
    .rs2_i         (bus.rs2),
    .ready_o       (bus.load_issue_ready),
    .error_o       (bus.load_resp_error),
    .head_filled_o (head_filled),
    .head_o        (head),
    .rs1_match_o   (rs1_match),
    .rs2_match_o   (rs2_match)
  );

  // Writes to x0 still consume their slot but never assert the write enable.
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    we_d   = 1'b0;
    if (bus.alu_valid) begin
      rd_d   = bus.alu_rd;
      data_d = bus.alu_data;
      we_d   = bus.alu_rd != '0;
    end else if (head_filled) begin
      rd_d   = head.rd;
      data_d = head.data;
      we_d   = head.rd != '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign bus.rd              = rd_q;
  assign bus.rd_data_in      = data_q;
  assign bus.rd_write_enable = we_q;

  // The in-flight write counts as pending until the register file has absorbed it.
  assign bus.rs1_busy = (bus.rs1 != '0) && ((|rs1_match) || (we_q && (rd_q == bus.rs1)));
  assign bus.rs2_busy = (bus.rs2 != '0) && ((|rs2_match) || (we_q && (rd_q == bus.rs2)));

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_register_writeback;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  register_writeback_if bus();

  register_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AddressBitWidth-1:0] rd;
    logic [DataBitWidth-1:0]    data;
    bit                         filled;
  } ment_t;

  ment_t                      mq[$];
  logic [AddressBitWidth-1:0] m_rd = '0;
  logic [DataBitWidth-1:0]    m_data = '0;
  bit                         m_we = 1'b0;
  bit                         m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [AddressBitWidth-1:0] rs);
    if (rs == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return m_we && (m_rd == rs);
  endfunction

  // Reference model: a FIFO of pending loads updated once per clock edge.
  always @(posedge clk or negedge rst_n) begin : model
    int  n;
    bit  hf;
    bit  found;
    if (!rst_n) begin
      mq.delete();
      m_rd = '0; m_data = '0; m_we = 1'b0; m_err = 1'b0;
    end else begin
      n  = mq.size();
      hf = (n > 0) && mq[0].filled;
      if (bus.alu_valid) chk("protocol_alu_rd_not_busy", 32'(m_busy(bus.alu_rd)), 32'd0);
      if (bus.load_resp_valid) begin
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (!found && !mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].data   = bus.load_resp_data;
            found        = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (bus.alu_valid) begin
        m_rd = bus.alu_rd; m_data = bus.alu_data; m_we = bus.alu_rd != '0;
      end else if (hf) begin
        m_rd = mq[0].rd; m_data = mq[0].data; m_we = mq[0].rd != '0;
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (bus.load_issue && n < LoadQueueDepth)
        mq.push_back('{rd: bus.load_issue_rd, data: '0, filled: 1'b0});
    end
  end

  always @(negedge clk) begin
    chk("cmp_rd", 32'(bus.rd), 32'(m_rd));
    chk("cmp_we", 32'(bus.rd_write_enable), 32'(m_we));
    chk("cmp_data", bus.rd_data_in, m_data);
    chk("cmp_ready", 32'(bus.load_issue_ready), 32'(mq.size() < LoadQueueDepth));
    chk("cmp_error", 32'(bus.load_resp_error), 32'(m_err));
    chk("cmp_rs1_busy", 32'(bus.rs1_busy), 32'(m_busy(bus.rs1)));
    chk("cmp_rs2_busy", 32'(bus.rs2_busy), 32'(m_busy(bus.rs2)));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.alu_valid       = 1'b0;
    bus.load_issue      = 1'b0;
    bus.load_resp_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = r; bus.alu_data = d;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.load_issue = 1'b1; bus.load_issue_rd = r;
  endtask

  task automatic resp(input logic [31:0] d);
    bus.load_resp_valid = 1'b1; bus.load_resp_data = d;
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.load_issue = 0; bus.load_issue_rd = '0;
    bus.load_resp_valid = 0; bus.load_resp_data = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", 32'(bus.rd_write_enable), 32'd0);
    chk("reset_rd", 32'(bus.rd), 32'd0);
    chk("reset_data", bus.rd_data_in, 32'd0);
    chk("reset_ready", 32'(bus.load_issue_ready), 32'd1);
    chk("reset_error", 32'(bus.load_resp_error), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: single ALU write, busy for exactly the in-flight cycle
    bus.rs1 = 5'd5;
    alu(5'd5, 32'hDEADBEEF); cyc();
    chk("t1_rd", 32'(bus.rd), 32'd5);
    chk("t1_we", 32'(bus.rd_write_enable), 32'd1);
    chk("t1_data", bus.rd_data_in, 32'hDEADBEEF);
    chk("t1_busy", 32'(bus.rs1_busy), 32'd1);
    cyc();
    chk("t1_we_drop", 32'(bus.rd_write_enable), 32'd0);
    chk("t1_busy_drop", 32'(bus.rs1_busy), 32'd0);
    chk("t1_rd_hold", 32'(bus.rd), 32'd5);

    // 2: single load, response two cycles after issue
    bus.rs1 = 5'd7;
    issue(5'd7); cyc();
    chk("t2_busy_issue", 32'(bus.rs1_busy), 32'd1);
    cyc();
    chk("t2_busy_wait", 32'(bus.rs1_busy), 32'd1);
    resp(32'h1234); cyc();
    chk("t2_no_same_cycle_drain", 32'(bus.rd_write_enable), 32'd0);
    cyc();
    chk("t2_we", 32'(bus.rd_write_enable), 32'd1);
    chk("t2_rd", 32'(bus.rd), 32'd7);
    chk("t2_data", bus.rd_data_in, 32'h1234);
    chk("t2_busy_write", 32'(bus.rs1_busy), 32'd1);
    cyc();
    chk("t2_busy_clear", 32'(bus.rs1_busy), 32'd0);

    // 3: fill the queue, ignored fifth issue, in-order drain
    bus.rs1 = 5'd9; bus.rs2 = 5'd3;
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i)); cyc();
    end
    chk("t3_full_ready", 32'(bus.load_issue_ready), 32'd0);
    chk("t3_rs2_busy", 32'(bus.rs2_busy), 32'd1);
    issue(5'd9); cyc();
    chk("t3_ignored_busy", 32'(bus.rs1_busy), 32'd0);
    resp(32'hA0); cyc();
    chk("t3_still_full", 32'(bus.load_issue_ready), 32'd0);
    resp(32'hA1); cyc();
    chk("t3_rd1", 32'(bus.rd), 32'd1);
    chk("t3_data1", bus.rd_data_in, 32'hA0);
    chk("t3_ready_after_pop", 32'(bus.load_issue_ready), 32'd1);
    resp(32'hA2); cyc();
    chk("t3_rd2", 32'(bus.rd), 32'd2);
    resp(32'hA3); cyc();
    chk("t3_rd3", 32'(bus.rd), 32'd3);
    chk("t3_data3", bus.rd_data_in, 32'hA2);
    cyc();
    chk("t3_rd4", 32'(bus.rd), 32'd4);
    chk("t3_data4", bus.rd_data_in, 32'hA3);
    cyc();
    chk("t3_idle_we", 32'(bus.rd_write_enable), 32'd0);

    // 4: filled head waits behind three ALU writes
    bus.rs1 = 5'd10; bus.rs2 = 5'd0;
    issue(5'd10); cyc();
    resp(32'h55); cyc();
    for (int i = 0; i < 3; i++) begin
      alu(5'(11 + i), 32'h100 + 32'(i)); cyc();
      chk("t4_alu_rd", 32'(bus.rd), 32'(11 + i));
      chk("t4_head_waits", 32'(bus.rs1_busy), 32'd1);
    end
    cyc();
    chk("t4_load_rd", 32'(bus.rd), 32'd10);
    chk("t4_load_data", bus.rd_data_in, 32'h55);
    cyc();

    // 5: orphan response sets sticky error; x0 writes stay disabled
    resp(32'hBAD); cyc();
    chk("t5_error", 32'(bus.load_resp_error), 32'd1);
    cyc();
    chk("t5_error_sticky", 32'(bus.load_resp_error), 32'd1);
    issue(5'd0); cyc();
    resp(32'h77); cyc();
    cyc();
    chk("t5_x0_load_we", 32'(bus.rd_write_enable), 32'd0);
    alu(5'd0, 32'h99); cyc();
    chk("t5_x0_alu_we", 32'(bus.rd_write_enable), 32'd0);
    chk("t5_empty_ready", 32'(bus.load_issue_ready), 32'd1);

    // 6: asynchronous reset while draining
    bus.rs1 = 5'd21; bus.rs2 = 5'd20;
    issue(5'd20); cyc();
    issue(5'd21); cyc();
    resp(32'hC0); cyc();
    resp(32'hC1); cyc();
    chk("t6_draining", 32'(bus.rd_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(bus.rd_write_enable), 32'd0);
    chk("t6_rst_rd", 32'(bus.rd), 32'd0);
    chk("t6_rst_data", bus.rd_data_in, 32'd0);
    chk("t6_rst_busy1", 32'(bus.rs1_busy), 32'd0);
    chk("t6_rst_busy2", 32'(bus.rs2_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    chk("t6_ready", 32'(bus.load_issue_ready), 32'd1);
    chk("t6_error_cleared", 32'(bus.load_resp_error), 32'd0);
    chk("t6_busy_after", 32'(bus.rs1_busy), 32'd0);
    chk("t6_we_after", 32'(bus.rd_write_enable), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
